reorder_buffer: RTL

- Circular reorder buffer (ROB) for the out-of-order RISC-V core.
- Allocates a ROB index for each issued instruction and drives the rename port of the register file (`issue_rename_*`).
- Captures results from the CDB and forwards operands to issue.
- Retires in program order, one entry per cycle, on the register file's `commit_*` port.
- On a branch mispredict at retire, it flushes itself and broadcasts `jump_rst`.

---
 rtl/reorder_buffer_pkg.sv | 31 +++
 rtl/reorder_buffer_if.sv | 64 ++++++
 rtl/reorder_buffer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// -----------------------------------------------------------------------------
// reorder_buffer_pkg
// Shared types and constants for the reorder buffer (ROB).
//   ROB_SIZE_LOG_DEFAULT : default log2 entry count, matching the core-wide
//                          ROB_SIZE_LOG used by the register file, reservation
//                          stations and load/store buffer.
//   rob_entry_t          : per-entry payload (everything except the busy bit).
//   is_mispredict()      : true when a resolved branch went against its
//                          prediction.
// -----------------------------------------------------------------------------
package reorder_buffer_pkg;

  localparam int ROB_SIZE_LOG_DEFAULT = 4;
  localparam int XLEN                 = 32;
  localparam int REG_W                = 5;

  typedef struct packed {
    logic             ready;
    logic [REG_W-1:0] dest;
    logic [XLEN-1:0]  value;
    logic             is_branch;
    logic             pred_taken;
    logic             taken;
    logic [XLEN-1:0]  alt_pc;
  } rob_entry_t;

  function automatic logic is_mispredict(input rob_entry_t e);
    return e.is_branch && (e.taken != e.pred_taken);
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// -----------------------------------------------------------------------------
// reorder_buffer_if
// Bundles every ROB-facing signal of the core: issue/allocation, rename
// request, operand query, CDB writeback, commit port and flush.
//   modport master : the core side (issue unit, CDB, register file).
//   modport slave  : the reorder buffer itself.
// Parameter ROB_SIZE_LOG sets the width of every ROB index.
// -----------------------------------------------------------------------------
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE_LOG = ROB_SIZE_LOG_DEFAULT
);

  // issue / allocation
  logic                    issue_valid;
  logic [REG_W-1:0]        issue_dest_reg;
  logic                    issue_is_branch;
  logic                    issue_pred_taken;
  logic [XLEN-1:0]         issue_alt_pc;
  logic                    rob_full;
  logic [ROB_SIZE_LOG-1:0] issue_reorder;
  logic                    issue_rename_valid;
  logic [REG_W-1:0]        issue_rename_reg;
  logic [ROB_SIZE_LOG-1:0] issue_rename_reorder;
  // operand query
  logic [ROB_SIZE_LOG-1:0] query_reorder1;
  logic [ROB_SIZE_LOG-1:0] query_reorder2;
  logic                    query_ready1;
  logic                    query_ready2;
  logic [XLEN-1:0]         query_value1;
  logic [XLEN-1:0]         query_value2;
  // CDB writeback
  logic                    cdb_valid;
  logic [ROB_SIZE_LOG-1:0] cdb_reorder;
  logic [XLEN-1:0]         cdb_value;
  logic                    cdb_taken;
  // commit / flush
  logic                    commit_valid;
  logic [XLEN-1:0]         commit_value;
  logic [REG_W-1:0]        commit_reg;
  logic [ROB_SIZE_LOG-1:0] commit_reorder;
  logic                    jump_rst;
  logic [XLEN-1:0]         jump_pc;

  modport master (
    output issue_valid, issue_dest_reg, issue_is_branch, issue_pred_taken, issue_alt_pc,
    output query_reorder1, query_reorder2,
    output cdb_valid, cdb_reorder, cdb_value, cdb_taken,
    input  rob_full, issue_reorder, issue_rename_valid, issue_rename_reg, issue_rename_reorder,
    input  query_ready1, query_ready2, query_value1, query_value2,
    input  commit_valid, commit_value, commit_reg, commit_reorder, jump_rst, jump_pc
  );

  modport slave (
    input  issue_valid, issue_dest_reg, issue_is_branch, issue_pred_taken, issue_alt_pc,
    input  query_reorder1, query_reorder2,
    input  cdb_valid, cdb_reorder, cdb_value, cdb_taken,
    output rob_full, issue_reorder, issue_rename_valid, issue_rename_reg, issue_rename_reorder,
    output query_ready1, query_ready2, query_value1, query_value2,
    output commit_valid, commit_value, commit_reg, commit_reorder, jump_rst, jump_pc
  );

endinterface

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// Circular reorder buffer: allocates an index per issued instruction, drives
// the register-file rename request, captures CDB results, answers operand
// queries and retires one entry per cycle in program order. A mispredicted
// branch at retire flushes the buffer and raises jump_rst / jump_pc.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   rdy  : global enable; every register holds while low
//   bus  : reorder_buffer_if.slave (issue, rename, query, CDB, commit, jump)
// Optional feature (macro ROB_CDB_BYPASS_EN): operand queries also see a
// result that is on the CDB in the same cycle.
// -----------------------------------------------------------------------------
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE_LOG = ROB_SIZE_LOG_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  reorder_buffer_if.slave bus
);

  localparam int ROB_SIZE = 1 << ROB_SIZE_LOG;

  typedef logic [ROB_SIZE_LOG-1:0] idx_t;
  typedef logic [ROB_SIZE_LOG:0]   cnt_t;

  localparam idx_t IDX_ONE  = idx_t'(1);
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t CNT_FULL = cnt_t'(ROB_SIZE);

  idx_t                head;
  idx_t                tail;
  cnt_t                count;
  logic [ROB_SIZE-1:0] busy;
  rob_entry_t          entries [ROB_SIZE];

  rob_entry_t head_entry;
  logic       accept;
  logic       do_commit;
  logic       flush;
  logic       cdb_write;

  assign head_entry = entries[head];

  // Full is judged on the pre-edge count, so a commit in the same cycle
  // does not free a slot for issue until the next cycle.
  assign bus.rob_full = (count == CNT_FULL);
  assign accept       = bus.issue_valid && !bus.rob_full && !bus.jump_rst && rdy;
  assign do_commit    = (count != '0) && head_entry.ready;
  assign flush        = do_commit && is_mispredict(head_entry);
  assign cdb_write    = bus.cdb_valid && !bus.jump_rst && busy[bus.cdb_reorder];

  assign bus.issue_reorder        = tail;
  assign bus.issue_rename_valid   = accept && (bus.issue_dest_reg != '0);
  assign bus.issue_rename_reg     = bus.issue_dest_reg;
  assign bus.issue_rename_reorder = tail;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    bus.query_ready1 = busy[bus.query_reorder1] && entries[bus.query_reorder1].ready;
    bus.query_value1 = entries[bus.query_reorder1].value;
    bus.query_ready2 = busy[bus.query_reorder2] && entries[bus.query_reorder2].ready;
    bus.query_value2 = entries[bus.query_reorder2].value;
`ifdef ROB_CDB_BYPASS_EN
    if (bus.cdb_valid && (bus.cdb_reorder == bus.query_reorder1) && busy[bus.query_reorder1]) begin
      bus.query_ready1 = 1'b1;
      bus.query_value1 = bus.cdb_value;
    end
    if (bus.cdb_valid && (bus.cdb_reorder == bus.query_reorder2) && busy[bus.query_reorder2]) begin
      bus.query_ready2 = 1'b1;
      bus.query_value2 = bus.cdb_value;
    end
`endif
  end

  // NOTE: the payload array is deliberately not reset; busy and count gate
  // every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (rdy && !flush) begin
      if (accept) begin
        entries[tail] <= '{ready:      1'b0,
                           dest:       bus.issue_dest_reg,
                           value:      '0,
                           is_branch:  bus.issue_is_branch,
                           pred_taken: bus.issue_pred_taken,
                           taken:      1'b0,
                           alt_pc:     bus.issue_alt_pc};
      end
      if (cdb_write) begin
        entries[bus.cdb_reorder].ready <= 1'b1;
        entries[bus.cdb_reorder].value <= bus.cdb_value;
        entries[bus.cdb_reorder].taken <= bus.cdb_taken;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every read in this
  // block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      busy               <= '0;
      bus.commit_valid   <= 1'b0;
      bus.commit_value   <= '0;
      bus.commit_reg     <= '0;
      bus.commit_reorder <= '0;
      bus.jump_rst       <= 1'b0;
      bus.jump_pc        <= '0;
    end else if (rdy) begin
      bus.commit_valid <= do_commit;
      if (do_commit) begin
        bus.commit_value   <= head_entry.value;
        bus.commit_reg     <= head_entry.dest;
        bus.commit_reorder <= head;
      end
      bus.jump_rst <= flush;
      if (flush) begin
        bus.jump_pc <= head_entry.alt_pc;
      end

      if (flush) begin
        // The branch itself still retires above; everything younger,
        // plus any issue or CDB event at this edge, is dropped.
        head  <= '0;
        tail  <= '0;
        count <= '0;
        busy  <= '0;
      end else begin
        if (accept) begin
          busy[tail] <= 1'b1;
          tail       <= tail + IDX_ONE;
        end
        if (do_commit) begin
          busy[head] <= 1'b0;
          head       <= head + IDX_ONE;
        end
        unique case ({accept, do_commit})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

endmodule
